// File: rtl/accumulate_arbiter.sv
// Round-robin owner of a shared accumulator: one requester per burst, sum returned tagged with its ID.
// Result path is combinational; arbitration stalls once DEPTH bursts are granted but not yet returned.
module accumulate_arbiter #(
  parameter int WIDTH = 16,
  parameter int N     = 4,
  parameter int DEPTH = 4,
  localparam int IDW  = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N-1:0]       s_stb,
  input  logic [N*WIDTH-1:0] s_dat,
  output logic [N-1:0]       s_rdy,
  output logic               acc_stb,
  output logic [WIDTH-1:0]   acc_dat,
  input  logic               acc_rdy,
  input  logic               res_stb,
  input  logic [WIDTH-1:0]   res_dat,
  output logic               res_rdy,
  output logic               m_stb,
  output logic [WIDTH-1:0]   m_dat,
  output logic [IDW-1:0]     m_id,
  input  logic               m_rdy
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

  typedef enum logic {IDLE, BURST} state_t;

  state_t         state;
  logic [IDW-1:0] grant;
  logic [IDW-1:0] last;
  logic           ack;
  logic [IDW-1:0] tag_mem [DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [PW:0]    count;

  logic           in_burst;
  logic           cur_stb;
  logic           close;
  logic           cand_vld;
  logic [IDW-1:0] cand;
  int             idx;
  logic           do_grant;
  logic           tag_vld;
  logic           pop;

  assign in_burst = (state == BURST);
  assign cur_stb  = s_stb[grant];
  // Same condition the accumulator uses to close and emit its sum.
  assign close    = in_burst & ack & ~cur_stb;

  // Nearest requester after the last granted one wins.
  always_comb begin
    cand_vld = 1'b0;
    cand     = '0;
    idx      = 0;
    for (int k = N; k >= 1; k--) begin
      idx = (int'(last) + k) % N;
      if (s_stb[IDW'(idx)]) begin
        cand_vld = 1'b1;
        cand     = IDW'(idx);
      end
    end
  end

  assign do_grant = ((state == IDLE) | close) & cand_vld & (count < DEPTH_C);

  assign acc_stb = in_burst & cur_stb;
  assign acc_dat = in_burst ? s_dat[int'(grant)*WIDTH +: WIDTH] : '0;

  always_comb begin
    s_rdy = '0;
    if (in_burst) s_rdy[grant] = acc_rdy;
  end

  assign tag_vld = (count != '0);
  assign m_stb   = res_stb & tag_vld;
  assign m_dat   = res_dat;
  assign m_id    = tag_mem[rd_ptr];
  assign res_rdy = m_rdy & tag_vld;
  assign pop     = m_stb & m_rdy;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      grant  <= '0;
      last   <= IDW'(N-1);
      ack    <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      ack <= acc_stb & acc_rdy;
      if (do_grant) begin
        grant <= cand;
        last  <= cand;
        state <= BURST;
      end else if (close) begin
        state <= IDLE;
      end
      if (do_grant) wr_ptr <= wr_ptr + 1'b1;
      if (pop)      rd_ptr <= rd_ptr + 1'b1;
      case ({do_grant, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_grant && !rst) tag_mem[wr_ptr] <= cand;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(pop && count == '0));
      assert (!(do_grant && count == DEPTH_C));
    end
  end
endmodule

// File: tb/tb_accumulate_arbiter.sv
// Bench for accumulate_arbiter: requester drivers, a saturating accumulator, and a burst/result model.
module tb_accumulate_arbiter;
  localparam int W     = 16;
  localparam int N     = 4;
  localparam int DEPTH = 4;
  localparam int IDW   = 2;
  localparam int GAP   = 32'h7fff_0000;
  localparam int MAXV  = 2**(W-1) - 1;
  localparam int MINV  = -(2**(W-1));

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   s_stb = '0;
  logic [N*W-1:0] s_dat = '0;
  logic [N-1:0]   s_rdy;
  logic           acc_stb;
  logic [W-1:0]   acc_dat;
  logic           acc_rdy = 1'b1;
  logic           res_stb = 1'b0;
  logic [W-1:0]   res_dat = '0;
  logic           res_rdy;
  logic           m_stb;
  logic [W-1:0]   m_dat;
  logic [IDW-1:0] m_id;
  logic           m_rdy = 1'b1;

  accumulate_arbiter #(.WIDTH(W), .N(N), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .s_stb(s_stb), .s_dat(s_dat), .s_rdy(s_rdy),
    .acc_stb(acc_stb), .acc_dat(acc_dat), .acc_rdy(acc_rdy),
    .res_stb(res_stb), .res_dat(res_dat), .res_rdy(res_rdy),
    .m_stb(m_stb), .m_dat(m_dat), .m_id(m_id), .m_rdy(m_rdy)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int sat(input int a);
    if (a > MAXV) return MAXV;
    if (a < MINV) return MINV;
    return a;
  endfunction

  // Requester drivers: each queue holds beats, GAP drops the strobe for one cycle.
  int           rq [N][$];
  logic [N-1:0] hs = '0;
  bit           rst_s = 1'b1;

  task automatic burst(input int i, input int n, input int v0, input int v1 = 0, input int v2 = 0);
    if (n > 0) rq[i].push_back(v0);
    if (n > 1) rq[i].push_back(v1);
    if (n > 2) rq[i].push_back(v2);
    rq[i].push_back(GAP);
  endtask

  always @(posedge clk) begin
    logic [31:0] v;
    #1;
    for (int i = 0; i < N; i++) begin
      if (rst_s) begin
        rq[i].delete();
        s_stb[i] = 1'b0;
      end else begin
        if (hs[i] && rq[i].size() > 0) void'(rq[i].pop_front());
        if (rq[i].size() > 0 && rq[i][0] == GAP) begin
          s_stb[i] = 1'b0;
          void'(rq[i].pop_front());
        end else if (rq[i].size() > 0) begin
          v = rq[i][0];
          s_stb[i] = 1'b1;
          s_dat[i*W +: W] = v[W-1:0];
        end else begin
          s_stb[i] = 1'b0;
        end
      end
    end
  end

  // Accumulator: saturating sum, closes on the first idle cycle after a beat, result queued.
  logic [W-1:0] acc_q [$];
  int           asum  = 0;
  bit           aopen = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      acc_q.delete();
      asum  = 0;
      aopen = 1'b0;
    end else begin
      if (res_stb && res_rdy) void'(acc_q.pop_front());
      if (acc_stb && acc_rdy) begin
        asum  = aopen ? sat(asum + int'($signed(acc_dat))) : int'($signed(acc_dat));
        aopen = 1'b1;
      end else if (aopen && !acc_stb) begin
        acc_q.push_back(asum[W-1:0]);
        aopen = 1'b0;
      end
    end
    res_stb <= (acc_q.size() != 0);
    res_dat <= (acc_q.size() != 0) ? acc_q[0] : '0;
  end

  // Model: bursts are recovered from requester handshakes, results must come back in order.
  int           cyc = 0;
  bit           mo_open = 1'b0;
  int           mo_id = 0;
  int           mo_sum = 0;
  int           opened = 0;
  int           popped = 0;
  logic [N-1:0] prev_stb = '0;
  logic [N-1:0] prev_hs = '0;
  bit           prev_rst = 1'b1;
  int exp_id [$];
  int exp_dat [$];
  int got_id [$];
  int got_dat [$];
  int got_cyc [$];
  int grant_log [$];
  int first_cyc [$];
  int last_cyc [$];
  int close_cyc [$];

  always @(negedge clk) begin
    cyc++;
    rst_s = rst;
    hs = s_stb & s_rdy;
    if (rst) begin
      mo_open = 1'b0;
      exp_id.delete();
      exp_dat.delete();
      opened = 0;
      popped = 0;
    end else begin
      check("s_rdy_onehot0", $onehot0(s_rdy), 1);
      if (!prev_rst)
        for (int i = 0; i < N; i++)
          if (prev_stb[i] && !prev_hs[i]) check("stb_held_until_accepted", s_stb[i], 1);
      check("feed_handshakes", $countones(hs), (acc_stb && acc_rdy) ? 1 : 0);
      for (int i = 0; i < N; i++) begin
        if (hs[i]) begin
          check("acc_dat", acc_dat, s_dat[i*W +: W]);
          if (!mo_open) begin
            mo_open = 1'b1;
            mo_id   = i;
            mo_sum  = int'($signed(s_dat[i*W +: W]));
            opened++;
            grant_log.push_back(i);
            first_cyc.push_back(cyc);
            last_cyc.push_back(cyc);
          end else begin
            check("burst_owner", i, mo_id);
            mo_sum = sat(mo_sum + int'($signed(s_dat[i*W +: W])));
            last_cyc[last_cyc.size()-1] = cyc;
          end
        end
      end
      if (mo_open && hs == '0 && !s_stb[mo_id]) begin
        exp_id.push_back(mo_id);
        exp_dat.push_back(mo_sum);
        close_cyc.push_back(cyc);
        mo_open = 1'b0;
      end
      check("m_stb", m_stb, res_stb);
      if (res_stb) check("res_rdy", res_rdy, m_rdy);
      if (m_stb) begin
        if (exp_id.size() == 0) begin
          check("m_stb_unexpected", 1, 0);
        end else begin
          check("m_id", m_id, exp_id[0]);
          check("m_dat", $signed(m_dat), exp_dat[0]);
          if (m_rdy) begin
            got_id.push_back(int'(m_id));
            got_dat.push_back(int'($signed(m_dat)));
            got_cyc.push_back(cyc);
            void'(exp_id.pop_front());
            void'(exp_dat.pop_front());
            popped++;
          end
        end
      end
      check("outstanding_le_depth", (opened - popped) <= DEPTH, 1);
      prev_stb = s_stb;
      prev_hs  = hs;
    end
    prev_rst = rst;
  end

  function automatic bit idle_now();
    for (int i = 0; i < N; i++) if (rq[i].size() != 0) return 1'b0;
    return !mo_open && exp_id.size() == 0 && acc_q.size() == 0 && s_stb == '0;
  endfunction

  task automatic wait_done(input string name, input int budget);
    bit ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk); #1;
      if (idle_now()) begin
        ok = 1'b1;
        break;
      end
    end
    check({name, "_completes"}, ok, 1);
  endtask

  task automatic clear_logs();
    got_id.delete(); got_dat.delete(); got_cyc.delete();
    grant_log.delete(); first_cyc.delete(); last_cyc.delete(); close_cyc.delete();
  endtask

  task automatic wait_beat(input int i, input int budget);
    bit ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk); #1;
      if (s_stb[i] && s_rdy[i]) begin
        ok = 1'b1;
        break;
      end
    end
    check("first_beat_accepted", ok, 1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk); #1;
    check("reset_s_rdy", s_rdy, 0);
    check("reset_acc_stb", acc_stb, 0);
    check("reset_m_stb", m_stb, 0);
    check("reset_res_rdy", res_rdy, 0);

    // Single burst 3,5,-2 from requester 1.
    @(posedge clk); #2;
    clear_logs();
    burst(1, 3, 3, 5, -2);
    wait_done("t1", 100);
    check("t1_results", got_id.size(), 1);
    if (got_id.size() >= 1) begin
      check("t1_id", got_id[0], 1);
      check("t1_sum", got_dat[0], 6);
      check("t1_latency", got_cyc[0] - close_cyc[0], 1);
    end

    // Saturation, then a sole requester re-granted with a fresh sum.
    @(posedge clk); #2;
    clear_logs();
    burst(3, 2, 20000, 20000);
    burst(3, 1, -1);
    wait_done("t3", 100);
    check("t3_results", got_id.size(), 2);
    if (got_id.size() >= 2) begin
      check("t3_id0", got_id[0], 3);
      check("t3_sum_sat", got_dat[0], 32767);
      check("t3_id1", got_id[1], 3);
      check("t3_sum_cleared", got_dat[1], -1);
    end

    // Downstream blocked: exactly DEPTH grants, then drain in order and resume.
    @(posedge clk); #2;
    clear_logs();
    m_rdy = 1'b0;
    for (int i = 0; i < N; i++) begin
      burst(i, 1, 1);
      burst(i, 1, 1);
    end
    begin
      bit ok = 1'b0;
      for (int k = 0; k < 100; k++) begin
        @(negedge clk); #1;
        if (grant_log.size() >= DEPTH) begin
          ok = 1'b1;
          break;
        end
      end
      check("t4_fill_grants", ok, 1);
    end
    repeat (6) @(negedge clk);
    #1;
    check("t4_grants_capped", grant_log.size(), DEPTH);
    check("t4_s_rdy_stalled", s_rdy, 0);
    check("t4_no_results", got_id.size(), 0);
    check("t4_head_valid", m_stb, 1);
    check("t4_head_id", m_id, 0);
    for (int k = 0; k < DEPTH && k < grant_log.size(); k++) check("t4_grant_order", grant_log[k], k);
    @(posedge clk); #2;
    m_rdy = 1'b1;
    wait_done("t4", 200);
    check("t4_results", got_id.size(), 2*N);
    for (int k = 0; k < got_id.size(); k++) begin
      check("t4_drain_id", got_id[k], k % N);
      check("t4_drain_sum", got_dat[k], 1);
    end

    // Two requesters alternating 2-beat bursts with a single bubble.
    @(posedge clk); #2;
    clear_logs();
    burst(0, 2, 1, 1);
    burst(0, 2, 1, 1);
    burst(2, 2, 1, 1);
    burst(2, 2, 1, 1);
    wait_done("t2", 200);
    check("t2_bursts", grant_log.size(), 4);
    check("t2_results", got_id.size(), 4);
    for (int k = 0; k < grant_log.size(); k++) check("t2_grant_order", grant_log[k], (k % 2) * 2);
    for (int k = 0; k < got_id.size(); k++) begin
      check("t2_id", got_id[k], (k % 2) * 2);
      check("t2_sum", got_dat[k], 2);
    end
    for (int k = 0; k + 1 < first_cyc.size(); k++)
      check("t2_one_bubble", first_cyc[k+1] - last_cyc[k], 2);

    // Accumulator stall mid-burst.
    @(posedge clk); #2;
    clear_logs();
    burst(1, 3, 4, 4, 4);
    wait_beat(1, 50);
    @(posedge clk); #2;
    acc_rdy = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); #1;
      check("t5_stall_s_rdy", s_rdy[1], 0);
      check("t5_stall_beat_held", acc_stb, 1);
      check("t5_stall_no_close", res_stb, 0);
    end
    @(posedge clk); #2;
    acc_rdy = 1'b1;
    wait_done("t5", 100);
    check("t5_results", got_id.size(), 1);
    if (got_id.size() >= 1) begin
      check("t5_id", got_id[0], 1);
      check("t5_sum", got_dat[0], 12);
    end

    // Reset during the second beat, then fresh bursts.
    @(posedge clk); #2;
    clear_logs();
    burst(2, 3, 7, 8, 9);
    wait_beat(2, 50);
    @(posedge clk); #2;
    rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    @(negedge clk); #1;
    check("t6_s_rdy", s_rdy, 0);
    check("t6_acc_stb", acc_stb, 0);
    check("t6_m_stb", m_stb, 0);
    check("t6_fifo_empty", res_rdy, 0);
    @(posedge clk); #2;
    clear_logs();
    burst(1, 1, 5);
    burst(3, 1, 6);
    wait_done("t6", 100);
    check("t6_results", got_id.size(), 2);
    if (got_id.size() >= 2) begin
      check("t6_id0", got_id[0], 1);
      check("t6_sum0", got_dat[0], 5);
      check("t6_id1", got_id[1], 3);
      check("t6_sum1", got_dat[1], 6);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/accumulate_arbiter.md
Name: accumulate_arbiter

Overview:
- Shares one accumulate block between N requesters.
- A requester owns the accumulator for a whole burst; the burst ends when that requester drops its strobe.
- The arbiter forces the single-cycle input gap that makes the accumulator close and emit its sum.
- Each sum is returned downstream tagged with the requester ID; grants rotate round-robin.

Parameters:
- WIDTH, 16, data width of samples and sums.
- N, 4, number of requesters (N >= 2).
- DEPTH, 4, tag FIFO depth = maximum bursts granted but not yet returned (power of 2).
- IDW, $clog2(N), width of requester ID (derived; do not override).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- s_stb  in  N  per-requester strobe; held high until beat accepted; low for >=1 cycle ends burst.
- s_dat  in  N*WIDTH  per-requester sample, requester i at bits [i*WIDTH +: WIDTH].
- s_rdy  out  N  per-requester ready.
- acc_stb  out  1  to accumulator s_stb.
- acc_dat  out  WIDTH  to accumulator s_dat.
- acc_rdy  in  1  from accumulator s_rdy.
- res_stb  in  1  from accumulator m_stb.
- res_dat  in  WIDTH  from accumulator m_dat.
- res_rdy  out  1  to accumulator m_rdy.
- m_stb  out  1  tagged result valid.
- m_dat  out  WIDTH  saturated burst sum.
- m_id  out  IDW  requester that produced m_dat.
- m_rdy  in  1  downstream ready.

Behaviour:
- States: IDLE, BURST. Registers: grant (IDW), last (IDW, last granted ID), ack (1), tag FIFO (DEPTH x IDW) with count.
- Reset (sync; also mid-burst) forces:
  - state=IDLE, grant=0, last=N-1, ack=0, FIFO empty.
  - All s_rdy=0, acc_stb=0, m_stb=0.
  - The accumulator shares rst, so a partial sum is discarded and no result is emitted.
- Arbitration:
  - Candidate = first i with s_stb[i]=1, searching last+1, last+2, ... mod N.
  - Grant is allowed only when count < DEPTH.
  - On grant: grant<=i, last<=i, state<=BURST, and i is pushed to the FIFO in the same cycle.
- IDLE: acc_stb=0, s_rdy=0. Evaluate arbitration every cycle; BURST starts the next cycle.
- BURST:
  - acc_stb = s_stb[grant]; acc_dat = s_dat[grant].
  - s_rdy[grant] = acc_rdy; all other s_rdy=0.
  - ack <= acc_stb & acc_rdy each cycle.
- Burst close:
  - Close cycle = BURST & ack & ~s_stb[grant]. This matches the accumulator's own clear condition, so exactly one idle input cycle closes it.
  - In the close cycle, arbitration is evaluated. With a candidate and space, grant switches and the new BURST starts the next cycle (1-cycle bubble minimum). Otherwise state<=IDLE.
  - The previous owner is excluded only by round-robin order. If it is the sole requester and reasserts, it is re-granted.
- Stall in burst:
  - s_stb[grant]=1 with acc_rdy=0 holds the beat; ack=0; no close.
  - Requesters must not drop an unaccepted strobe (protocol rule). The bench asserts this.
- Leading gap: BURST entered but s_stb[grant] low before any accepted beat (ack=0) cannot occur, because grant requires s_stb=1 and the strobe must hold.
- Result path (combinational):
  - m_stb = res_stb & (count != 0).
  - m_dat = res_dat; m_id = FIFO head.
  - res_rdy = m_rdy & (count != 0).
  - Pop on m_stb & m_rdy.
- FIFO: push and pop in the same cycle leaves count unchanged. Pop when empty and push when full cannot occur by construction; assert on either.
- Throughput:
  - Latency from close cycle to m_stb is 1 cycle (accumulator register).
  - Results leave in grant order.
  - With m_rdy held low, at most DEPTH bursts are granted, then arbitration stalls.

Test Plan:
1. Requester 1 sends 3,5,-2 on consecutive cycles, then drops stb; m_rdy=1 -> m_stb one cycle after close cycle, m_dat=6, m_id=1.
2. Requesters 0 and 2 both continuously request 2-beat bursts of value 1 -> grants alternate 0,2,0,2; exactly 1 bubble cycle between bursts; each result m_dat=2 with alternating m_id.
3. WIDTH=16, requester 3 sends 20000,20000 -> m_dat=32767 (saturated), m_id=3; next burst from same requester sends -1 -> m_dat=-1 (accumulator cleared).
4. m_rdy=0, all requesters send 1-beat bursts -> exactly DEPTH grants (IDs 0,1,2,3), then all s_rdy=0; raise m_rdy -> results drain in order 0,1,2,3 and granting resumes.
5. acc_rdy forced low for 2 cycles mid-burst (beats 4,4,4) -> s_rdy[grant] low during the stall, no close, sum 12 returned once.
6. rst asserted in 2nd beat of a burst -> next cycle s_rdy=0, acc_stb=0, m_stb=0, FIFO empty; no result for the aborted burst; a new burst afterwards returns its correct sum.
